// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose
//   Responder side of the input-feature read handshake. A tile of
//   TILE_H x TILE_W words is read from the feature SRAM in row-major order.
//   Each row starts at a row base that advances by a programmable stride.
//   Read data returns MEM_LAT cycles after each strobe and is streamed out in
//   issue order. if_done tells the input-feature controller that the whole
//   tile has been delivered.
//
// Ports
//   clk        in   1       clock
//   rst        in   1       synchronous, active-high reset (highest priority)
//   if_read    in   1       fetch enable; reads are issued only while high
//   clr_if     in   1       tile start/restart, only meaningful with if_read
//   if_base    in   ADDR_W  tile base address, captured on an accepted start
//   if_stride  in   ADDR_W  row-to-row address delta, captured on a start
//   if_done    out  1       tile complete, held high while in DONE
//   mem_rd_en  out  1       SRAM read strobe
//   mem_addr   out  ADDR_W  SRAM read address
//   mem_rdata  in   DATA_W  SRAM read data, valid MEM_LAT cycles after strobe
//   if_valid   out  1       if_data carries a feature word this cycle
//   if_data    out  DATA_W  feature word, forced to zero when not valid
//   if_last    out  1       marks the final word of the tile
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int TILE_H  = 4,
    parameter int TILE_W  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read,
    input  logic              clr_if,
    input  logic [ADDR_W-1:0] if_base,
    input  logic [ADDR_W-1:0] if_stride,
    output logic              if_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              if_last
);

    // Counter widths never drop below one bit so a 1-row or 1-column tile
    // still has a legal (constant zero) counter.
    localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_stride;
    logic [MEM_LAT-1:0] r_vpipe;
    logic [MEM_LAT-1:0] r_lpipe;

    logic [1:0] w_next_state;
    logic       w_start;
    logic       w_issue;
    logic       w_row_end;
    logic       w_tile_end;
    logic       w_issue_last;
    logic       w_pipe_valid;
    logic       w_pipe_last;

    // A start request is honoured in every state, so it doubles as the
    // restart condition while a tile is in progress.
    assign w_start = if_read & clr_if;

    // While fetching, the strobe simply follows if_read. In a restart cycle
    // the strobe still fires at the old address; its word is discarded by
    // the pipe flush that accompanies the restart.
    assign w_issue      = (r_state == S_FETCH) & if_read;
    assign w_row_end    = (r_col == COL_LAST);
    assign w_tile_end   = w_row_end & (r_row == ROW_LAST);
    assign w_issue_last = w_issue & w_tile_end;

    assign w_pipe_valid = r_vpipe[MEM_LAT-1];
    assign w_pipe_last  = r_lpipe[MEM_LAT-1];

    // Next-state selection. A start always lands in FETCH regardless of the
    // current state; otherwise FETCH ends on the final issue, DRAIN ends
    // once the final word has left the valid pipe, and DONE is held until
    // the controller drops if_read.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_FETCH: if (w_issue_last) w_next_state = S_DRAIN;
                S_DRAIN: if (w_pipe_valid && w_pipe_last) w_next_state = S_DONE;
                S_DONE:  if (!if_read) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address generation. The row base is kept as a running sum so the
    // address is just row base plus column, with no multiplier. A start
    // reloads everything from the ports; each issue advances the column and,
    // at the end of a row, steps the row base by the stride. Address
    // arithmetic wraps naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_stride   <= '0;
        end else if (w_start) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= if_base;
            r_stride   <= if_stride;
        end else if (w_issue) begin
            if (w_row_end) begin
                r_col      <= '0;
                r_row_base <= r_row_base + r_stride;
                if (w_tile_end) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Valid pipe: a MEM_LAT-deep shift register of the read strobe, with a
    // matching shift register carrying the end-of-tile marker. A start
    // empties both, which suppresses every word still in flight for an
    // aborted tile.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_vpipe <= '0;
            r_lpipe <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            r_lpipe[0] <= w_issue_last;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

    // Output mapping. Data is zeroed outside valid cycles so downstream
    // logic never sees stale SRAM contents.
    assign mem_rd_en = w_issue;
    assign mem_addr  = r_row_base + ADDR_W'(r_col);
    assign if_valid  = w_pipe_valid;
    assign if_last   = w_pipe_valid & w_pipe_last;
    assign if_data   = w_pipe_valid ? mem_rdata : '0;
    assign if_done   = (r_state == S_DONE);

    // Protocol guarantees: if_last only ever accompanies a valid word, and
    // if_done never rises unless the final word was output the cycle before.
    a_last_needs_valid : assert property (
        @(posedge clk) disable iff (rst) if_last |-> if_valid);

    a_done_after_last : assert property (
        @(posedge clk) disable iff (rst) $rose(if_done) |-> $past(if_last));

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Purpose
//   Self-checking bench for if_fetch_unit, built as a 2x3 tile with a
//   one-cycle SRAM. A recorder pushes the expected address list and word
//   list of every accepted tile into queues; a monitor pops and compares on
//   each strobe / valid word and tracks when if_done must be high.
//
// Ports
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int TH  = 2;
    localparam int TW  = 3;
    localparam int LAT = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_read;
    logic          clr_if;
    logic [AW-1:0] if_base;
    logic [AW-1:0] if_stride;
    logic          if_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_data;
    logic          if_last;

    logic [AW-1:0] addrQ[$];
    word_t         dataQ[$];

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 0;
    bit rstPrev     = 1;
    bit expDone     = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TILE_H (TH),
        .TILE_W (TW),
        .MEM_LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_read  (if_read),
        .clr_if   (clr_if),
        .if_base  (if_base),
        .if_stride(if_stride),
        .if_done  (if_done),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .if_valid (if_valid),
        .if_data  (if_data),
        .if_last  (if_last)
    );

    // Contents of the feature SRAM: a fixed scramble of the address.
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // One-cycle SRAM; returns noise when not read so data gating is visible.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? memWord(mem_addr) : 8'($urandom);
    end

    // Counted comparison; reports one FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Recorder: every start accepted at this edge replaces the expectation
    // queues with the full row-major tile; reset empties them.
    always @(posedge clk) begin
        logic [AW-1:0] a;
        word_t         w;
        if (rst) begin
            armed = 1;
            addrQ.delete();
            dataQ.delete();
        end else if (if_read && clr_if) begin
            addrQ.delete();
            dataQ.delete();
            for (int r = 0; r < TH; r++) begin
                for (int c = 0; c < TW; c++) begin
                    a      = if_base + AW'(r) * if_stride + AW'(c);
                    w.data = memWord(a);
                    w.last = (r == TH - 1) && (c == TW - 1);
                    addrQ.push_back(a);
                    dataQ.push_back(w);
                end
            end
        end
    end

    // Monitor: compares strobes, addresses, words and if_done each cycle,
    // then derives whether if_done must be high in the next cycle.
    always @(negedge clk) begin
        word_t e;
        bit    lastNow;
        if (armed) begin
            lastNow = 0;
            checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(if_read && (addrQ.size() > 0)));
            if (mem_rd_en && addrQ.size() > 0) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(addrQ.pop_front()));
            end
            if (dataQ.size() == 0) begin
                checkOutput("if_valid_spurious", 32'(if_valid), 32'(0));
            end else if (if_valid) begin
                e = dataQ.pop_front();
                checkOutput("if_data", 32'(if_data), 32'(e.data));
                checkOutput("if_last", 32'(if_last), 32'(e.last));
                lastNow = e.last;
            end
            if (!if_valid) begin
                checkOutput("if_data_idle", 32'(if_data), 32'(0));
                checkOutput("if_last_idle", 32'(if_last), 32'(0));
            end
            checkOutput("if_done", 32'(if_done), 32'(expDone));
            if (rstPrev) begin
                checkOutput("mem_addr_reset", 32'(mem_addr), 32'(0));
            end
            if (rst)                      expDone = 0;
            else if (if_read && clr_if)   expDone = 0;
            else if (lastNow)             expDone = 1;
            else if (!if_read)            expDone = 0;
            rstPrev = rst;
        end
    end

    // Drive one cycle of inputs, then move to just after the next edge.
    task automatic applyStimulus(input logic rd, input logic clr,
                                 input logic [AW-1:0] b, input logic [AW-1:0] s,
                                 input logic r);
        rst       = r;
        if_read   = rd;
        clr_if    = clr;
        if_base   = b;
        if_stride = s;
        @(posedge clk);
        #1;
    endtask

    // Start a tile and keep fetching until if_done, optionally stalling
    // (fixed window or random), restarting once, and then either releasing
    // the controller handshake or leaving the unit in DONE.
    task automatic runTile(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input int stallLo, input int stallHi,
                           input int restartAt,
                           input logic [AW-1:0] rb, input logic [AW-1:0] rs,
                           input bit randMode, input bit holdDone,
                           output int doneAt);
        int   k;
        bit   restarted;
        logic rd;
        doneAt    = -1;
        restarted = 0;
        k         = 0;
        applyStimulus(1'b1, 1'b1, b, s, 1'b0);
        for (int n = 0; n < 200; n++) begin
            k++;
            if (if_done) begin
                doneAt = k;
                break;
            end
            if (!restarted && k == restartAt) begin
                applyStimulus(1'b1, 1'b1, rb, rs, 1'b0);
                restarted = 1;
                k         = 0;
            end else if (randMode) begin
                rd = ($urandom_range(0, 3) != 0);
                applyStimulus(rd, rd ? 1'b0 : 1'($urandom), AW'($urandom), AW'($urandom), 1'b0);
            end else begin
                rd = !(k >= stallLo && k <= stallHi);
                applyStimulus(rd, 1'b0, AW'($urandom), AW'($urandom), 1'b0);
            end
        end
        if (doneAt < 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no if_done, expected one within 200 cycles");
        end else if (!holdDone) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
            checkOutput("done_clear", 32'(if_done), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneAt;
        int ra;

        // Reset state.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
        checkOutput("reset_done",  32'(if_done),   32'(0));
        checkOutput("reset_rd_en", 32'(mem_rd_en), 32'(0));
        checkOutput("reset_valid", 32'(if_valid),  32'(0));
        checkOutput("reset_last",  32'(if_last),   32'(0));
        checkOutput("reset_addr",  32'(mem_addr),  32'(0));
        checkOutput("reset_data",  32'(if_data),   32'(0));
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);

        // Plain 2x3 tile: words T2..T7, done at T8.
        runTile(16'h0010, 16'h0008, -1, -1, 0, '0, '0, 0, 0, doneAt);
        checkOutput("t1_done_cycle", 32'(doneAt), 32'(8));

        // Address wrap at the top of the address space.
        runTile(16'hFFFE, 16'h0001, -1, -1, 0, '0, '0, 0, 0, doneAt);
        checkOutput("t2_done_cycle", 32'(doneAt), 32'(8));

        // Two-cycle stall in the middle of the first row.
        runTile(16'h0010, 16'h0008, 3, 4, 0, '0, '0, 0, 0, doneAt);
        checkOutput("t3_done_cycle", 32'(doneAt), 32'(10));

        // Restart at T4 with a new base; completion measured from restart.
        runTile(16'h0010, 16'h0008, -1, -1, 4, 16'h0100, 16'h0008, 0, 0, doneAt);
        checkOutput("t4_done_cycle", 32'(doneAt), 32'(8));

        // Reset while draining the last word.
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h0008, 1'b0);
        for (int t = 1; t <= 6; t++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
        checkOutput("t5_rst_done",  32'(if_done),   32'(0));
        checkOutput("t5_rst_valid", 32'(if_valid),  32'(0));
        checkOutput("t5_rst_rd_en", 32'(mem_rd_en), 32'(0));
        checkOutput("t5_rst_addr",  32'(mem_addr),  32'(0));
        runTile(16'h0040, 16'h0010, -1, -1, 0, '0, '0, 0, 0, doneAt);
        checkOutput("t5_fresh_done_cycle", 32'(doneAt), 32'(8));

        // Back-to-back tiles, the second one started directly from DONE.
        runTile(16'h0200, 16'h0004, -1, -1, 0, '0, '0, 0, 1, doneAt);
        checkOutput("t6a_done_cycle", 32'(doneAt), 32'(8));
        runTile(16'h0300, 16'hFFFC, -1, -1, 0, '0, '0, 0, 0, doneAt);
        checkOutput("t6b_done_cycle", 32'(doneAt), 32'(8));

        // Randomised tiles with stalls, don't-care clr_if and restarts.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
            runTile(AW'($urandom), AW'($urandom), -1, -1, ra,
                    AW'($urandom), AW'($urandom), 1, 1'($urandom), doneAt);
        end

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("words_outstanding", 32'(dataQ.size()), 32'(0));
        checkOutput("addrs_outstanding", 32'(addrQ.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
